// File: rtl/fifo_pkt_arb_pkg.sv
// Shared types for the two-source packet arbiter: FSM states, grant codes
// and the command count-code decode.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // One-hot owner codes, also used as grant_o values
    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC1     = 2'b01;
    localparam logic [1:0] SRC2     = 2'b10;

    // Count code -> number of data words following the command word.
    // Codes outside 1..4 carry no data.
    function automatic logic [3:0] cnt_decode(input logic [2:0] code);
        case (code)
            3'd1:    return 4'd1;
            3'd2:    return 4'd2;
            3'd3:    return 4'd4;
            3'd4:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_pkt_arb_if.sv
// Source-FIFO read side, output-FIFO write side and status of the arbiter.
// master = arbiter, slave = surrounding FIFOs / environment.
interface fifo_pkt_arb_if #(
    parameter int DW = 32
);
    logic [DW-1:0] f1_rd_data_i;
    logic [DW-1:0] f2_rd_data_i;
    logic          f1_empty_i;
    logic          f2_empty_i;
    logic          f1_rd_en_o;
    logic          f2_rd_en_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_en_o;
    logic          full_i;
    logic [1:0]    grant_o;
    logic          busy_o;

    modport master (
        input  f1_rd_data_i, f2_rd_data_i, f1_empty_i, f2_empty_i, full_i,
        output f1_rd_en_o, f2_rd_en_o, wr_data_o, wr_en_o, grant_o, busy_o
    );

    modport slave (
        output f1_rd_data_i, f2_rd_data_i, f1_empty_i, f2_empty_i, full_i,
        input  f1_rd_en_o, f2_rd_en_o, wr_data_o, wr_en_o, grant_o, busy_o
    );
endinterface

// File: rtl/fifo_pkt_arb_rr.sv
// Two-request round-robin picker: on contention the source that did not
// own the last completed packet wins.
module rr_arb2
    import fifo_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt
);

    // Pure combinational one-hot grant
    always_comb begin
        gnt = SRC_NONE;
        case (req)
            2'b01:   gnt = SRC1;
            2'b10:   gnt = SRC2;
            2'b11:   gnt = (last == SRC1) ? SRC2 : SRC1;
            default: gnt = SRC_NONE;
        endcase
    end

endmodule

// File: rtl/fifo_pkt_arb.sv
// Moves whole packets (command word + N data words) from two FWFT source
// FIFOs into one output FIFO, never interleaving packets of the two sources.
module fifo_pkt_arb
    import fifo_arb_pkg::*;
#(
    parameter int DW       = 32,
    parameter int CNTSHIFT = 0,
    parameter int CNTMASK  = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fifo_pkt_arb_if.master    bus
);

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    rem_q, rem_d;
    logic [1:0]    arb_gnt;
    logic          src_empty;
    logic          xfer;
    logic [DW-1:0] src_data;
    logic [DW-1:0] code_w;
    logic          code_ok;
    logic [3:0]    pkt_n;

    // Arbitration only matters in IDLE; the registered grant owns the packet
    rr_arb2 u_rr (
        .req  ({~bus.f2_empty_i, ~bus.f1_empty_i}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    assign src_data = grant_q[1] ? bus.f2_rd_data_i : bus.f1_rd_data_i;

    // Empty flag of the current owner; no owner counts as empty
    always_comb begin
        src_empty = 1'b1;
        case (grant_q)
            SRC1:    src_empty = bus.f1_empty_i;
            SRC2:    src_empty = bus.f2_empty_i;
            default: src_empty = 1'b1;
        endcase
    end

    // Reset gates the transfer so nothing is popped while rst_i is high
    assign xfer = !rst_i && (state_q != ST_IDLE) && !src_empty && !bus.full_i;

    // Count field; any bit above the 3-bit code makes it an unknown code
    assign code_w  = (src_data >> CNTSHIFT) & DW'(CNTMASK);
    assign code_ok = ((code_w >> 3) == '0);
    assign pkt_n   = code_ok ? cnt_decode(code_w[2:0]) : 4'd0;

    assign bus.wr_en_o    = xfer;
    assign bus.wr_data_o  = src_data;
    assign bus.f1_rd_en_o = xfer & grant_q[0];
    assign bus.f2_rd_en_o = xfer & grant_q[1];
    assign bus.grant_o    = grant_q;
    assign bus.busy_o     = (state_q != ST_IDLE);

    // Next-state: grant in IDLE, decode length on the command, count data
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != SRC_NONE) begin
                    grant_d = arb_gnt;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (xfer) begin
                    if (pkt_n == 4'd0) begin
                        state_d = ST_IDLE;
                        grant_d = SRC_NONE;
                        last_d  = grant_q;
                    end else begin
                        rem_d   = pkt_n;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = ST_IDLE;
                        grant_d = SRC_NONE;
                        last_d  = grant_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = SRC_NONE;
            end
        endcase
    end

    // State register; last owner resets to source 2 so source 1 wins first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= SRC_NONE;
            last_q  <= SRC2;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
        end
    end

endmodule
